// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants: button bit indices, default resolution, colour width
package vga_pkg;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   localparam int RES_H     = 640;
   localparam int RES_V     = 480;

   localparam int RGB_WIDTH = 3;

endpackage

// File: rtl/sprite_pos.sv
// rtl/sprite_pos.sv - one sprite: position register with clamped stepping and pixel hit test
module sprite_pos #(
   parameter int SPRITE_W     = 16,
   parameter int SPRITE_H     = 16,
   parameter int STEP         = 2,
   parameter int RESOLUTION_H = 640,
   parameter int RESOLUTION_V = 480,
   parameter int HPOS_WIDTH   = 10,
   parameter int VPOS_WIDTH   = 10,
   parameter int INIT_X       = 0,
   parameter int INIT_Y       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  move,
   input  logic [3:0]            btn,
   input  logic [HPOS_WIDTH-1:0] hpos,
   input  logic [VPOS_WIDTH-1:0] vpos,
   output logic                  hit
);
   import vga_pkg::*;

   // Coordinates carry one spare MSB so step/compare arithmetic never wraps.
   localparam logic [HPOS_WIDTH:0] X_MAX  = (HPOS_WIDTH+1)'(RESOLUTION_H - SPRITE_W);
   localparam logic [HPOS_WIDTH:0] X_STEP = (HPOS_WIDTH+1)'(STEP);
   localparam logic [HPOS_WIDTH:0] X_SIZE = (HPOS_WIDTH+1)'(SPRITE_W);
   localparam logic [HPOS_WIDTH:0] X_INIT = (HPOS_WIDTH+1)'(INIT_X);
   localparam logic [VPOS_WIDTH:0] Y_MAX  = (VPOS_WIDTH+1)'(RESOLUTION_V - SPRITE_H);
   localparam logic [VPOS_WIDTH:0] Y_STEP = (VPOS_WIDTH+1)'(STEP);
   localparam logic [VPOS_WIDTH:0] Y_SIZE = (VPOS_WIDTH+1)'(SPRITE_H);
   localparam logic [VPOS_WIDTH:0] Y_INIT = (VPOS_WIDTH+1)'(INIT_Y);

   logic [HPOS_WIDTH:0] x, x_next, hpos_ext;
   logic [VPOS_WIDTH:0] y, y_next, vpos_ext;

   assign hpos_ext = {1'b0, hpos};
   assign vpos_ext = {1'b0, vpos};

   // Next position: opposing buttons cancel, each axis clamps to the visible area.
   always_comb begin
      x_next = x;
      y_next = y;
      if (btn[BTN_LEFT] && !btn[BTN_RIGHT])
         x_next = (x < X_STEP) ? '0 : x - X_STEP;
      else if (btn[BTN_RIGHT] && !btn[BTN_LEFT])
         x_next = (x + X_STEP > X_MAX) ? X_MAX : x + X_STEP;
      if (btn[BTN_UP] && !btn[BTN_DOWN])
         y_next = (y < Y_STEP) ? '0 : y - Y_STEP;
      else if (btn[BTN_DOWN] && !btn[BTN_UP])
         y_next = (y + Y_STEP > Y_MAX) ? Y_MAX : y + Y_STEP;
   end

   // Position register: home position on reset, steps only when this sprite is moved.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x <= X_INIT;
         y <= Y_INIT;
      end else if (move) begin
         x <= x_next;
         y <= y_next;
      end
   end

   assign hit = (hpos_ext >= x) && (hpos_ext < x + X_SIZE) &&
                (vpos_ext >= y) && (vpos_ext < y + Y_SIZE);

endmodule

// File: rtl/sprite_mixer.sv
// rtl/sprite_mixer.sv - N movable sprites over a background with priority mux and collision flag
module sprite_mixer #(
   parameter int N_SPRITES     = 4,
   parameter int SPRITE_W      = 16,
   parameter int SPRITE_H      = 16,
   parameter int STEP          = 2,
   parameter int RESOLUTION_H  = vga_pkg::RES_H,
   parameter int RESOLUTION_V  = vga_pkg::RES_V,
   parameter int HPOS_WIDTH    = 10,
   parameter int VPOS_WIDTH    = 10,
   parameter int RGB_WIDTH     = vga_pkg::RGB_WIDTH,
   parameter logic [N_SPRITES*RGB_WIDTH-1:0] SPRITE_COLORS = {3'b111, 3'b100, 3'b010, 3'b001}
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic [3:0]                                    btn,
   input  logic [((N_SPRITES > 1) ? $clog2(N_SPRITES) : 1)-1:0] sel,
   input  logic                                          display_on,
   input  logic [HPOS_WIDTH-1:0]                         hpos,
   input  logic [VPOS_WIDTH-1:0]                         vpos,
   input  logic [RGB_WIDTH-1:0]                          fb_rgb,
   output logic [RGB_WIDTH-1:0]                          rgb,
   output logic                                          collision
);

   if ((N_SPRITES < 1) || (N_SPRITES > 8)) begin : g_bad_count
      $error("sprite_mixer: N_SPRITES must be 1..8");
   end
   if ((N_SPRITES - 1) * 2 * SPRITE_W + SPRITE_W > RESOLUTION_H) begin : g_bad_layout
      $error("sprite_mixer: home positions of the sprites do not fit in RESOLUTION_H");
   end

   logic                   frame_tick;
   logic [N_SPRITES-1:0]   hits;
   logic                   multi_hit;
   logic                   overlap;
   logic [RGB_WIDTH-1:0]   pix;

   // First line below the visible area, column 0: once per frame.
   assign frame_tick = (vpos == VPOS_WIDTH'(RESOLUTION_V)) && (hpos == '0);

   for (genvar i = 0; i < N_SPRITES; i++) begin : g_sprite
      sprite_pos #(
         .SPRITE_W     (SPRITE_W),
         .SPRITE_H     (SPRITE_H),
         .STEP         (STEP),
         .RESOLUTION_H (RESOLUTION_H),
         .RESOLUTION_V (RESOLUTION_V),
         .HPOS_WIDTH   (HPOS_WIDTH),
         .VPOS_WIDTH   (VPOS_WIDTH),
         .INIT_X       (i * 2 * SPRITE_W),
         .INIT_Y       ((RESOLUTION_V - SPRITE_H) / 2)
      ) u_pos (
         .clk     (clk),
         .reset_n (reset_n),
         .move    (frame_tick && (32'(sel) == i)),
         .btn     (btn),
         .hpos    (hpos),
         .vpos    (vpos),
         .hit     (hits[i])
      );
   end

   // More than one bit set in hits: clearing the lowest set bit leaves something.
   assign multi_hit = |(hits & (hits - N_SPRITES'(1)));

   // Priority mux: the lowest-index covering sprite wins, else background.
   always_comb begin
      pix = fb_rgb;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (hits[i])
            pix = SPRITE_COLORS[i*RGB_WIDTH +: RGB_WIDTH];
      end
   end

   // Registered colour output, blanked outside the visible area.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rgb <= '0;
      else
         rgb <= display_on ? pix : '0;
   end

   // Sticky overlap accumulates over a frame and is handed to collision on the tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overlap   <= 1'b0;
         collision <= 1'b0;
      end else if (frame_tick) begin
         collision <= overlap;
         overlap   <= 1'b0;
      end else if (display_on && multi_hit) begin
         overlap   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprite_mixer.sv
// tb/tb_sprite_mixer.sv - scoreboard bench for sprite_mixer with directed pixel probes
module tb_sprite_mixer;

   localparam logic [2:0] FB = 3'b110;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [1:0] sel = 2'd0;
   logic       display_on = 1'b0;
   logic [9:0] hpos = 10'd1;
   logic [9:0] vpos = 10'd0;
   logic [2:0] fb_rgb = FB;
   logic [2:0] rgb;
   logic       collision;

   sprite_mixer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn        (btn),
      .sel        (sel),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos),
      .fb_rgb     (fb_rgb),
      .rgb        (rgb),
      .collision  (collision)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_col;
      logic [2:0] exp;
      string      name;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   logic probe_req = 1'b0;
   logic probe_pipe = 1'b0;

   always @(posedge clk) probe_pipe <= probe_req;

   always @(negedge clk) begin
      if (probe_pipe) begin
         exp_t       e;
         logic [2:0] act;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: output presented with no expectation queued");
         end else begin
            e   = sbq.pop_front();
            act = e.is_col ? {2'b00, collision} : rgb;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %0b expected %0b", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic push_exp(input bit is_col, input logic [2:0] exp_v, input string name);
      exp_t e;
      e.is_col = is_col;
      e.exp    = exp_v;
      e.name   = name;
      sbq.push_back(e);
   endtask

   task automatic probe(input int h, input int v, input bit d, input logic [2:0] fb,
                        input logic [2:0] exp_v, input string name);
      hpos       = 10'(h);
      vpos       = 10'(v);
      display_on = d;
      fb_rgb     = fb;
      probe_req  = 1'b1;
      push_exp(1'b0, exp_v, name);
      @(posedge clk); #1;
      probe_req  = 1'b0;
      display_on = 1'b0;
   endtask

   task automatic check_col(input bit exp_v, input string name);
      probe_req = 1'b1;
      push_exp(1'b1, {2'b00, exp_v}, name);
      @(posedge clk); #1;
      probe_req = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         display_on = 1'b0;
         hpos = 10'd0;
         vpos = 10'd480;
         @(posedge clk); #1;
         hpos = 10'd1;
         vpos = 10'd0;
         @(posedge clk); #1;
      end
   endtask

   task automatic direct_check(input logic [2:0] act, input logic [2:0] exp_v, input string name);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp_v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      probe(5, 240, 1'b1, FB, 3'b000, "reset_rgb");
      check_col(1'b0, "reset_collision");
      reset_n = 1'b1;

      probe(0,   232, 1'b1, FB, 3'b001, "s0_top_left");
      probe(15,  247, 1'b1, FB, 3'b001, "s0_bottom_right");
      probe(16,  240, 1'b1, FB, FB,     "s0_right_edge");
      probe(32,  232, 1'b1, FB, 3'b010, "s1_home");
      probe(64,  232, 1'b1, FB, 3'b100, "s2_home");
      probe(96,  232, 1'b1, FB, 3'b111, "s3_home");
      probe(112, 240, 1'b1, FB, FB,     "s3_right_edge");
      probe(40,  231, 1'b1, FB, FB,     "above_row");
      probe(40,  248, 1'b1, FB, FB,     "below_row");
      check_col(1'b0, "collision_idle");

      sel = 2'd1; btn = 4'b1000; tick(3); btn = 4'b0000;
      probe(37, 240, 1'b1, FB, FB,     "s1_x38_left_edge");
      probe(38, 240, 1'b1, FB, 3'b010, "s1_x38");
      probe(53, 240, 1'b1, FB, 3'b010, "s1_x38_last_col");
      probe(54, 240, 1'b1, FB, FB,     "s1_x38_right_edge");
      probe(0,  240, 1'b1, FB, 3'b001, "s0_held");
      probe(64, 240, 1'b1, FB, 3'b100, "s2_held");
      probe(96, 240, 1'b1, FB, 3'b111, "s3_held");
      btn = 4'b1100; tick(1); btn = 4'b0000;
      probe(37, 240, 1'b1, FB, FB,     "lr_cancel_edge");
      probe(38, 240, 1'b1, FB, 3'b010, "lr_cancel_x38");

      sel = 2'd2; btn = 4'b1001; tick(1);
      probe(65, 240, 1'b1, FB, FB,     "diag_left_edge");
      probe(66, 230, 1'b1, FB, 3'b100, "diag_corner");
      probe(66, 229, 1'b1, FB, FB,     "diag_top_edge");
      btn = 4'b0011; tick(1);
      probe(66, 230, 1'b1, FB, 3'b100, "ud_cancel_corner");
      probe(66, 229, 1'b1, FB, FB,     "ud_cancel_top");
      btn = 4'b0110; tick(1); btn = 4'b0000;
      probe(64, 232, 1'b1, FB, 3'b100, "diag_back_home");
      probe(64, 231, 1'b1, FB, FB,     "diag_back_top");

      sel = 2'd0; btn = 4'b0100; tick(5); btn = 4'b0000;
      probe(0,  240, 1'b1, FB, 3'b001, "s0_clamp_left");
      probe(16, 240, 1'b1, FB, FB,     "s0_clamp_edge");

      sel = 2'd3; btn = 4'b1000; tick(263);
      probe(621, 240, 1'b1, FB, FB,     "s3_x622_edge");
      probe(622, 240, 1'b1, FB, 3'b111, "s3_x622");
      tick(1);
      probe(623, 240, 1'b1, FB, FB,     "s3_x624_edge");
      probe(624, 240, 1'b1, FB, 3'b111, "s3_x624");
      probe(639, 240, 1'b1, FB, 3'b111, "s3_x624_last_col");
      tick(2);
      probe(623, 240, 1'b1, FB, FB,     "s3_clamp_right_edge");
      probe(624, 240, 1'b1, FB, 3'b111, "s3_clamp_right");
      btn = 4'b0001; tick(120); btn = 4'b0000;
      probe(630, 0,  1'b1, FB, 3'b111, "s3_clamp_top");
      probe(630, 16, 1'b1, FB, FB,     "s3_clamp_top_edge");

      sel = 2'd1; btn = 4'b0100; tick(20); btn = 4'b0000;
      probe(5, 240, 1'b1, FB, 3'b001, "priority_s0_over_s1");
      check_col(1'b0, "collision_before_tick");
      tick(1);
      check_col(1'b1, "collision_after_tick");
      btn = 4'b1000; tick(10); btn = 4'b0000;
      check_col(1'b0, "collision_cleared");
      probe(20, 240, 1'b1, FB, 3'b010, "s1_x20");
      probe(16, 240, 1'b1, FB, FB,     "gap_s0_s1");

      probe(300, 10,  1'b1, 3'b101, 3'b101, "background");
      probe(0,   240, 1'b0, FB,     3'b000, "blanked");

      btn = 4'b0100; tick(3); btn = 4'b0000;
      probe(14, 240, 1'b1, FB, 3'b001, "overlap_again");
      tick(1);
      check_col(1'b1, "collision_pre_reset");
      hpos = 10'd5; vpos = 10'd100; display_on = 1'b1; fb_rgb = FB;
      @(posedge clk); #1;
      direct_check(rgb, FB, "rgb_pre_reset");
      #2;
      reset_n = 1'b0;
      #1;
      direct_check(rgb, 3'b000, "async_reset_rgb");
      direct_check({2'b00, collision}, 3'b000, "async_reset_collision");
      display_on = 1'b0;
      @(posedge clk); #1;
      probe(5, 240, 1'b1, FB, 3'b000, "in_reset_rgb");
      reset_n = 1'b1;
      probe(32,  240, 1'b1, FB, 3'b010, "s1_back_home");
      probe(16,  240, 1'b1, FB, FB,     "s1_home_gap");
      probe(96,  240, 1'b1, FB, 3'b111, "s3_back_home");
      probe(624, 240, 1'b1, FB, FB,     "s3_old_spot_empty");
      probe(64,  232, 1'b1, FB, 3'b100, "s2_back_home");
      check_col(1'b0, "collision_after_reset");

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
